// File: rtl/datapath_sequencer_if.sv
// Command handshake plus datapath control bundle between a command source,
// the sequencer and the Lab 5 datapath.
interface datapath_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_kind;
  logic [1:0]        cmd_aluop;
  logic [2:0]        cmd_rd;
  logic [2:0]        cmd_rn;
  logic [2:0]        cmd_rm;
  logic [1:0]        cmd_shift;
  logic [IMM_W-1:0]  cmd_imm;

  logic              busy;
  logic              done;
  logic [2:0]        readnum;
  logic [2:0]        writenum;
  logic              vsel;
  logic              loada;
  logic              loadb;
  logic              asel;
  logic              bsel;
  logic [1:0]        shift;
  logic [1:0]        ALUop;
  logic              loadc;
  logic              loads;
  logic              write;
  logic [DATA_W-1:0] datapath_in;

  modport master (
    output cmd_valid, cmd_kind, cmd_aluop, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm,
    input  cmd_ready, busy, done, readnum, writenum, vsel, loada, loadb, asel, bsel,
           shift, ALUop, loadc, loads, write, datapath_in
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_aluop, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm,
    output cmd_ready, busy, done, readnum, writenum, vsel, loada, loadb, asel, bsel,
           shift, ALUop, loadc, loads, write, datapath_in
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Command-driven FSM stepping the Lab 5 datapath through read, execute and writeback.
// Build option SEQ_IMM_SEXT_EN: sign-extend the MOVI immediate instead of zero-extending.
module datapath_sequencer #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_sequencer_if.slave  bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOADA = 3'd1;
  localparam logic [2:0] S_LOADB = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [1:0] K_MOVI = 2'b00;
  localparam logic [1:0] K_MOV  = 2'b01;
  localparam logic [1:0] K_ALU  = 2'b10;
  localparam logic [1:0] K_CMP  = 2'b11;

  localparam int PAD_W = DATA_W - IMM_W;

  logic [2:0]       state_q, state_d;
  logic             done_q, done_d;
  logic [1:0]       kind_q, aluop_q, shift_q;
  logic [2:0]       rd_q, rn_q, rm_q;
  logic [IMM_W-1:0] imm_q;
  logic             accept;
  logic [DATA_W-1:0] imm_ext;

  assign accept = bus.cmd_valid && (state_q == S_IDLE);

`ifdef SEQ_IMM_SEXT_EN
  assign imm_ext = {{PAD_W{imm_q[IMM_W-1]}}, imm_q};
`else
  assign imm_ext = {{PAD_W{1'b0}}, imm_q};
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_kind)
            K_MOVI:  state_d = S_WRITE;
            K_MOV:   state_d = S_LOADB;
            default: state_d = S_LOADA;
          endcase
        end
      end
      S_LOADA: state_d = S_LOADB;
      S_LOADB: state_d = S_EXEC;
      S_EXEC: begin
        // CMP only updates status flags, so it finishes without a writeback
        if (kind_q == K_CMP) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      kind_q  <= 2'b00;
      aluop_q <= 2'b00;
      shift_q <= 2'b00;
      rd_q    <= 3'd0;
      rn_q    <= 3'd0;
      rm_q    <= 3'd0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        kind_q  <= bus.cmd_kind;
        aluop_q <= bus.cmd_aluop;
        shift_q <= bus.cmd_shift;
        rd_q    <= bus.cmd_rd;
        rn_q    <= bus.cmd_rn;
        rm_q    <= bus.cmd_rm;
        imm_q   <= bus.cmd_imm;
      end
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;

  always_comb begin
    bus.readnum     = 3'd0;
    bus.writenum    = 3'd0;
    bus.vsel        = 1'b0;
    bus.loada       = 1'b0;
    bus.loadb       = 1'b0;
    bus.asel        = 1'b0;
    bus.bsel        = 1'b0;
    bus.shift       = 2'b00;
    bus.ALUop       = 2'b00;
    bus.loadc       = 1'b0;
    bus.loads       = 1'b0;
    bus.write       = 1'b0;
    bus.datapath_in = '0;
    case (state_q)
      S_LOADA: begin
        bus.readnum = rn_q;
        bus.loada   = 1'b1;
      end
      S_LOADB: begin
        bus.readnum = rm_q;
        bus.loadb   = 1'b1;
      end
      S_EXEC: begin
        bus.shift = shift_q;
        case (kind_q)
          K_MOV: begin
            // asel zeroes the A operand so ADD passes shifted B through
            bus.asel  = 1'b1;
            bus.loadc = 1'b1;
          end
          K_ALU: begin
            bus.ALUop = aluop_q;
            bus.loadc = 1'b1;
            bus.loads = 1'b1;
          end
          K_CMP: begin
            bus.ALUop = 2'b01;
            bus.loads = 1'b1;
          end
          default: ;
        endcase
      end
      S_WRITE: begin
        bus.writenum = rd_q;
        bus.write    = 1'b1;
        if (kind_q == K_MOVI) begin
          bus.vsel        = 1'b1;
          bus.datapath_in = imm_ext;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed table-driven bench for datapath_sequencer plus hand sequences for
// async reset, back-to-back acceptance and valid-while-busy.
module tb_datapath_sequencer;
  localparam int DATA_W = 16;
  localparam int IMM_W  = 8;

  logic clk;
  logic reset;

  datapath_sequencer_if #(.DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();

  datapath_sequencer #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {busy,done,rdy,readnum,writenum,vsel,loada,loadb,asel,bsel,shift,ALUop,loadc,loads,write,datapath_in}
  typedef logic [36:0] word_t;

  typedef struct {
    logic [1:0]      kind;
    logic [1:0]      aluop;
    logic [2:0]      rd;
    logic [2:0]      rn;
    logic [2:0]      rm;
    logic [1:0]      shift;
    logic [7:0]      imm;
    int              ncyc;
    logic [5:0][36:0] exp;
  } vec_t;

  vec_t vecs [7];

  function automatic word_t w(input logic busy, input logic done, input logic rdy,
                              input logic [2:0] rnum, input logic [2:0] wnum,
                              input logic vsel, input logic la, input logic lb,
                              input logic asel, input logic bsel,
                              input logic [1:0] sh, input logic [1:0] op,
                              input logic lc, input logic ls, input logic wr,
                              input logic [15:0] dp);
    return {busy, done, rdy, rnum, wnum, vsel, la, lb, asel, bsel, sh, op, lc, ls, wr, dp};
  endfunction

  function automatic word_t w_idle();
    return w(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
  endfunction
  function automatic word_t w_done();
    return w(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
  endfunction
  function automatic word_t w_la(input logic [2:0] rn);
    return w(1'b1, 1'b0, 1'b0, rn, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
  endfunction
  function automatic word_t w_lb(input logic [2:0] rm);
    return w(1'b1, 1'b0, 1'b0, rm, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
  endfunction
  function automatic word_t w_ex(input logic asel, input logic [1:0] sh, input logic [1:0] op,
                                 input logic lc, input logic ls);
    return w(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, asel, 1'b0, sh, op, lc, ls, 1'b0, 16'h0);
  endfunction
  function automatic word_t w_wr(input logic [2:0] wn, input logic vsel, input logic [15:0] dp);
    return w(1'b1, 1'b0, 1'b0, 3'd0, wn, vsel, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, dp);
  endfunction

  function automatic vec_t mkcmd(input logic [1:0] kind, input logic [1:0] aluop,
                                 input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                                 input logic [1:0] sh, input logic [7:0] imm);
    vec_t v;
    v.kind = kind; v.aluop = aluop; v.rd = rd; v.rn = rn; v.rm = rm;
    v.shift = sh; v.imm = imm; v.ncyc = 0; v.exp = '0;
    return v;
  endfunction

  function automatic word_t snap();
    return {bus.busy, bus.done, bus.cmd_ready, bus.readnum, bus.writenum, bus.vsel,
            bus.loada, bus.loadb, bus.asel, bus.bsel, bus.shift, bus.ALUop,
            bus.loadc, bus.loads, bus.write, bus.datapath_in};
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] kind, input logic [1:0] aluop,
                           input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                           input logic [1:0] sh, input logic [7:0] imm);
    bus.cmd_kind  = kind;
    bus.cmd_aluop = aluop;
    bus.cmd_rd    = rd;
    bus.cmd_rn    = rn;
    bus.cmd_rm    = rm;
    bus.cmd_shift = sh;
    bus.cmd_imm   = imm;
  endtask

  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    drive_cmd(r[1:0], r[3:2], r[6:4], r[9:7], r[12:10], r[14:13], r[22:15]);
  endtask

`ifdef SEQ_IMM_SEXT_EN
  localparam logic [15:0] DP_85 = 16'hFF85;
  localparam logic [15:0] DP_9C = 16'hFF9C;
`else
  localparam logic [15:0] DP_85 = 16'h0085;
  localparam logic [15:0] DP_9C = 16'h009C;
`endif

  initial begin
    vecs[0] = mkcmd(2'b00, 2'b00, 3'd3, 3'd0, 3'd0, 2'b00, 8'h85);
    vecs[0].ncyc = 3;
    vecs[0].exp[0] = w_wr(3'd3, 1'b1, DP_85);
    vecs[0].exp[1] = w_done();
    vecs[0].exp[2] = w_idle();

    vecs[1] = mkcmd(2'b10, 2'b10, 3'd4, 3'd1, 3'd2, 2'b01, 8'h00);
    vecs[1].ncyc = 6;
    vecs[1].exp[0] = w_la(3'd1);
    vecs[1].exp[1] = w_lb(3'd2);
    vecs[1].exp[2] = w_ex(1'b0, 2'b01, 2'b10, 1'b1, 1'b1);
    vecs[1].exp[3] = w_wr(3'd4, 1'b0, 16'h0);
    vecs[1].exp[4] = w_done();
    vecs[1].exp[5] = w_idle();

    vecs[2] = mkcmd(2'b11, 2'b11, 3'd7, 3'd5, 3'd6, 2'b10, 8'hAA);
    vecs[2].ncyc = 5;
    vecs[2].exp[0] = w_la(3'd5);
    vecs[2].exp[1] = w_lb(3'd6);
    vecs[2].exp[2] = w_ex(1'b0, 2'b10, 2'b01, 1'b0, 1'b1);
    vecs[2].exp[3] = w_done();
    vecs[2].exp[4] = w_idle();

    vecs[3] = mkcmd(2'b01, 2'b10, 3'd2, 3'd1, 3'd7, 2'b11, 8'h55);
    vecs[3].ncyc = 5;
    vecs[3].exp[0] = w_lb(3'd7);
    vecs[3].exp[1] = w_ex(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
    vecs[3].exp[2] = w_wr(3'd2, 1'b0, 16'h0);
    vecs[3].exp[3] = w_done();
    vecs[3].exp[4] = w_idle();

    vecs[4] = mkcmd(2'b10, 2'b11, 3'd6, 3'd0, 3'd3, 2'b00, 8'hFF);
    vecs[4].ncyc = 6;
    vecs[4].exp[0] = w_la(3'd0);
    vecs[4].exp[1] = w_lb(3'd3);
    vecs[4].exp[2] = w_ex(1'b0, 2'b00, 2'b11, 1'b1, 1'b1);
    vecs[4].exp[3] = w_wr(3'd6, 1'b0, 16'h0);
    vecs[4].exp[4] = w_done();
    vecs[4].exp[5] = w_idle();

    vecs[5] = mkcmd(2'b00, 2'b01, 3'd0, 3'd4, 3'd4, 2'b01, 8'h7F);
    vecs[5].ncyc = 3;
    vecs[5].exp[0] = w_wr(3'd0, 1'b1, 16'h007F);
    vecs[5].exp[1] = w_done();
    vecs[5].exp[2] = w_idle();

    vecs[6] = mkcmd(2'b10, 2'b01, 3'd1, 3'd7, 3'd7, 2'b10, 8'h00);
    vecs[6].ncyc = 6;
    vecs[6].exp[0] = w_la(3'd7);
    vecs[6].exp[1] = w_lb(3'd7);
    vecs[6].exp[2] = w_ex(1'b0, 2'b10, 2'b01, 1'b1, 1'b1);
    vecs[6].exp[3] = w_wr(3'd1, 1'b0, 16'h0);
    vecs[6].exp[4] = w_done();
    vecs[6].exp[5] = w_idle();

    bus.cmd_valid = 1'b0;
    drive_cmd(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 8'h00);
    reset = 1'b1;
    #12;
    check("reset_state", snap(), w_idle());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", snap(), w_idle());

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive_cmd(vecs[i].kind, vecs[i].aluop, vecs[i].rd, vecs[i].rn, vecs[i].rm,
                vecs[i].shift, vecs[i].imm);
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      scramble();
      for (int k = 0; k < vecs[i].ncyc; k++) begin
        @(negedge clk);
        check($sformatf("vec%0d_cyc%0d", i, k + 1), snap(), vecs[i].exp[k]);
      end
    end

    // Async reset while an ALU command sits in LOADB
    @(negedge clk);
    drive_cmd(2'b10, 2'b10, 3'd4, 3'd1, 3'd2, 2'b01, 8'h00);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_loada", snap(), w_la(3'd1));
    @(posedge clk);
    #1;
    check("rst_pre_loadb", snap(), w_lb(3'd2));
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_outputs", snap(), w_idle());
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_done_cyc%0d", k), snap(), w_idle());
    end

    // MOV then MOVI with valid held high: second accepted in the done cycle
    @(negedge clk);
    drive_cmd(2'b01, 2'b00, 3'd2, 3'd0, 3'd5, 2'b01, 8'h00);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    drive_cmd(2'b00, 2'b00, 3'd6, 3'd0, 3'd0, 2'b00, 8'h9C);
    @(negedge clk);
    check("b2b_n1_loadb", snap(), w_lb(3'd5));
    @(negedge clk);
    check("b2b_n2_exec", snap(), w_ex(1'b1, 2'b01, 2'b00, 1'b1, 1'b0));
    @(negedge clk);
    check("b2b_n3_write", snap(), w_wr(3'd2, 1'b0, 16'h0));
    @(negedge clk);
    check("b2b_n4_done_ready", snap(), w_done());
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    scramble();
    @(negedge clk);
    check("b2b_n5_movi_write", snap(), w_wr(3'd6, 1'b1, DP_9C));
    @(negedge clk);
    check("b2b_n6_done", snap(), w_done());
    @(negedge clk);
    check("b2b_n7_idle", snap(), w_idle());

    // cmd_valid pulsed while a CMP is in flight must be ignored
    @(negedge clk);
    drive_cmd(2'b11, 2'b00, 3'd0, 3'd3, 3'd4, 2'b00, 8'h00);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("busy_c1_loada", snap(), w_la(3'd3));
    drive_cmd(2'b00, 2'b00, 3'd1, 3'd0, 3'd0, 2'b00, 8'hFF);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    check("busy_c2_loadb", snap(), w_lb(3'd4));
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("busy_c3_exec", snap(), w_ex(1'b0, 2'b00, 2'b01, 1'b0, 1'b1));
    @(negedge clk);
    check("busy_c4_done", snap(), w_done());
    @(negedge clk);
    check("busy_c5_idle", snap(), w_idle());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
